// File: rtl/frame_config_sequencer_if.sv
// -----------------------------------------------------------------------------
// frame_config_sequencer_if
// Bitstream word stream carried from the configuration controller into the
// column sequencer.
//   s_data  : 32-bit bitstream word
//   s_valid : s_data valid
//   s_ready : sequencer accepts word (transfer = s_valid & s_ready)
// master : word source (drives s_data/s_valid, observes s_ready)
// slave  : the sequencer (observes s_data/s_valid, drives s_ready)
// -----------------------------------------------------------------------------
interface frame_config_sequencer_if;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_config_sequencer.sv
// -----------------------------------------------------------------------------
// frame_config_sequencer
// Converts a bitstream word stream into the FrameData / FrameStrobe config bus
// of one fabric column. Hunts for SyncWord, decodes frame headers
// (idx = bits[4:0], cnt = bits[15:8]) and writes cnt data words into
// consecutive frames starting at idx, each followed by a one-hot strobe.
// Ports:
//   CLK            : configuration clock, rising edge
//   resetn         : synchronous active-low reset
//   bs             : bitstream stream (slave modport: s_data/s_valid/s_ready)
//   FrameData      : registered frame data to the tiles
//   FrameStrobe    : one-hot frame write strobe, one-cycle pulse
//   busy           : session in progress (state != HUNT)
//   err            : sticky error (bad header index or frame overrun)
//   frames_written : saturating count of strobes issued
// -----------------------------------------------------------------------------
module frame_config_sequencer #(
   parameter int          FrameBitsPerRow = 32,
   parameter int          MaxFramesPerCol = 20,
   parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
   input  logic                       CLK,
   input  logic                       resetn,
   frame_config_sequencer_if.slave    bs,
   output logic [FrameBitsPerRow-1:0] FrameData,
   output logic [MaxFramesPerCol-1:0] FrameStrobe,
   output logic                       busy,
   output logic                       err,
   output logic [15:0]                frames_written
);

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_HEADER = 2'd1;
   localparam logic [1:0] ST_DATA   = 2'd2;
   localparam logic [1:0] ST_STROBE = 2'd3;

   localparam logic [4:0] LAST_PTR = 5'(MaxFramesPerCol - 1);
   localparam logic [MaxFramesPerCol-1:0] ONE_HOT0 = {{(MaxFramesPerCol-1){1'b0}}, 1'b1};

   logic [1:0]                 state_q, state_d;
   logic [4:0]                 ptr_q, ptr_d;
   logic [7:0]                 cnt_q, cnt_d;
   logic                       err_q, err_d;
   logic [FrameBitsPerRow-1:0] data_q, data_d;
   logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
   logic [15:0]                fw_q, fw_d;
   logic                       ready_q, ready_d;

   logic       xfer;
   logic [4:0] hdr_idx;
   logic [7:0] hdr_cnt;

   assign xfer    = bs.s_valid & ready_q;
   assign hdr_idx = bs.s_data[4:0];
   assign hdr_cnt = bs.s_data[15:8];

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      data_d   = data_q;
      fw_d     = fw_q;
      strobe_d = '0;
      case (state_q)
         ST_HUNT: begin
            if (xfer && (bs.s_data == SyncWord)) begin
               state_d = ST_HEADER;
               err_d   = 1'b0;
            end
         end
         ST_HEADER: begin
            if (xfer) begin
               if (hdr_cnt == 8'd0) begin
                  // Zero-length header means we lost framing: resync quietly.
                  state_d = ST_HUNT;
               end else if (hdr_idx > LAST_PTR) begin
                  err_d   = 1'b1;
                  state_d = ST_HUNT;
               end else begin
                  ptr_d   = hdr_idx;
                  cnt_d   = hdr_cnt;
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (xfer) begin
               data_d  = bs.s_data;
               state_d = ST_STROBE;
            end
         end
         default: begin
            // Strobe is registered out of this state, so it fires one cycle
            // after FrameData was loaded and while it is still stable.
            strobe_d = ONE_HOT0 << ptr_q;
            if (fw_q != 16'hFFFF) fw_d = fw_q + 16'd1;
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               state_d = ST_HEADER;
            end else if (ptr_q == LAST_PTR) begin
               // Column overrun: no wrap-around into frame 0.
               err_d   = 1'b1;
               state_d = ST_HUNT;
            end else begin
               ptr_d   = ptr_q + 5'd1;
               state_d = ST_DATA;
            end
         end
      endcase
      // Ready is registered from the next state so it is glitch-free and
      // already low for the whole strobe cycle.
      ready_d = (state_d != ST_STROBE);
   end

   always_ff @(posedge CLK) begin
      if (!resetn) begin
         state_q  <= ST_HUNT;
         ptr_q    <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         data_q   <= '0;
         strobe_q <= '0;
         fw_q     <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
         fw_q     <= fw_d;
         ready_q  <= ready_d;
      end
   end

   assign bs.s_ready     = ready_q;
   assign FrameData      = data_q;
   assign FrameStrobe    = strobe_q;
   assign busy           = (state_q != ST_HUNT);
   assign err            = err_q;
   assign frames_written = fw_q;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_config_sequencer
// Directed bench for frame_config_sequencer: reset, basic write, bad header,
// overrun, stalls, zero-count desync and mid-session reset.
// -----------------------------------------------------------------------------
module tb_frame_config_sequencer;

   localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

   logic        CLK = 1'b0;
   logic        resetn;
   logic [31:0] FrameData;
   logic [19:0] FrameStrobe;
   logic        busy;
   logic        err;
   logic [15:0] frames_written;

   int vectors    = 0;
   int miscompares = 0;

   frame_config_sequencer_if bus ();

   frame_config_sequencer #(
      .FrameBitsPerRow (32),
      .MaxFramesPerCol (20),
      .SyncWord        (SYNC)
   ) dut (
      .CLK            (CLK),
      .resetn         (resetn),
      .bs             (bus),
      .FrameData      (FrameData),
      .FrameStrobe    (FrameStrobe),
      .busy           (busy),
      .err            (err),
      .frames_written (frames_written)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full output snapshot after an edge.
   task automatic chk_all(input string tag, input logic [19:0] stb, input logic [31:0] fd,
                          input logic rdy, input logic bsy, input logic er, input logic [15:0] fw);
      chk({tag, ".strobe"}, 32'(FrameStrobe), 32'(stb));
      chk({tag, ".fdata"},  FrameData, fd);
      chk({tag, ".ready"},  32'(bus.s_ready), 32'(rdy));
      chk({tag, ".busy"},   32'(busy), 32'(bsy));
      chk({tag, ".err"},    32'(err), 32'(er));
      chk({tag, ".fw"},     32'(frames_written), 32'(fw));
   endtask

   task automatic drive(input logic v, input logic [31:0] d);
      bus.s_valid = v;
      bus.s_data  = d;
   endtask

   initial begin
      // Reset held 3 cycles with a sync word presented.
      resetn = 1'b0;
      drive(1'b1, SYNC);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_all("reset", 20'h0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
      end
      resetn = 1'b1;
      drive(1'b0, 32'h0);
      tick();
      chk_all("post_reset", 20'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd0);

      // Basic write: idx=3, cnt=2, words A and B.
      drive(1'b1, SYNC);              tick();
      chk_all("bw.sync", 20'h0, 32'h0, 1'b1, 1'b1, 1'b0, 16'd0);
      drive(1'b1, 32'h0000_0203);     tick();
      chk_all("bw.hdr", 20'h0, 32'h0, 1'b1, 1'b1, 1'b0, 16'd0);
      drive(1'b1, 32'hAAAA_0001);     tick();
      chk_all("bw.dA", 20'h0, 32'hAAAA_0001, 1'b0, 1'b1, 1'b0, 16'd0);
      drive(1'b1, 32'hBBBB_0002);     tick();
      chk_all("bw.sA", 20'h00008, 32'hAAAA_0001, 1'b1, 1'b1, 1'b0, 16'd1);
      tick();
      chk_all("bw.dB", 20'h0, 32'hBBBB_0002, 1'b0, 1'b1, 1'b0, 16'd1);
      drive(1'b0, 32'h0);             tick();
      chk_all("bw.sB", 20'h00010, 32'hBBBB_0002, 1'b1, 1'b1, 1'b0, 16'd2);
      tick();
      chk_all("bw.hold", 20'h0, 32'hBBBB_0002, 1'b1, 1'b1, 1'b0, 16'd2);

      // Bad header idx=20 from HEADER.
      drive(1'b1, 32'h0000_0114);     tick();
      chk_all("bad.hdr", 20'h0, 32'hBBBB_0002, 1'b1, 1'b0, 1'b1, 16'd2);
      drive(1'b1, 32'h1234_5678);     tick();
      chk_all("bad.junk", 20'h0, 32'hBBBB_0002, 1'b1, 1'b0, 1'b1, 16'd2);
      drive(1'b1, SYNC);              tick();
      chk_all("bad.clr", 20'h0, 32'hBBBB_0002, 1'b1, 1'b1, 1'b0, 16'd2);

      // Overrun: idx=18, cnt=5.
      drive(1'b1, 32'h0000_0512);     tick();
      chk_all("ov.hdr", 20'h0, 32'hBBBB_0002, 1'b1, 1'b1, 1'b0, 16'd2);
      drive(1'b1, 32'hC0C0_0003);     tick();
      chk_all("ov.dC", 20'h0, 32'hC0C0_0003, 1'b0, 1'b1, 1'b0, 16'd2);
      drive(1'b1, 32'hD0D0_0004);     tick();
      chk_all("ov.sC", 20'h40000, 32'hC0C0_0003, 1'b1, 1'b1, 1'b0, 16'd3);
      tick();
      chk_all("ov.dD", 20'h0, 32'hD0D0_0004, 1'b0, 1'b1, 1'b0, 16'd3);
      drive(1'b1, 32'hE0E0_0005);     tick();
      chk_all("ov.sD", 20'h80000, 32'hD0D0_0004, 1'b1, 1'b0, 1'b1, 16'd4);
      tick();
      chk_all("ov.dE", 20'h0, 32'hD0D0_0004, 1'b1, 1'b0, 1'b1, 16'd4);

      // Stalls during DATA/STROBE: idx=2, cnt=3.
      drive(1'b1, SYNC);              tick();
      chk_all("st.sync", 20'h0, 32'hD0D0_0004, 1'b1, 1'b1, 1'b0, 16'd4);
      drive(1'b1, 32'hFF00_0302);     tick();
      chk_all("st.hdr", 20'h0, 32'hD0D0_0004, 1'b1, 1'b1, 1'b0, 16'd4);
      drive(1'b0, 32'h5555_5555);     tick();
      chk_all("st.gap1", 20'h0, 32'hD0D0_0004, 1'b1, 1'b1, 1'b0, 16'd4);
      tick();
      chk_all("st.gap2", 20'h0, 32'hD0D0_0004, 1'b1, 1'b1, 1'b0, 16'd4);
      drive(1'b1, 32'hF000_000F);     tick();
      chk_all("st.dF", 20'h0, 32'hF000_000F, 1'b0, 1'b1, 1'b0, 16'd4);
      drive(1'b0, 32'h6666_6666);     tick();
      chk_all("st.sF", 20'h00004, 32'hF000_000F, 1'b1, 1'b1, 1'b0, 16'd5);
      tick();
      chk_all("st.gap3", 20'h0, 32'hF000_000F, 1'b1, 1'b1, 1'b0, 16'd5);
      drive(1'b1, 32'h9000_0009);     tick();
      chk_all("st.dG", 20'h0, 32'h9000_0009, 1'b0, 1'b1, 1'b0, 16'd5);
      drive(1'b0, 32'h0);             tick();
      chk_all("st.sG", 20'h00008, 32'h9000_0009, 1'b1, 1'b1, 1'b0, 16'd6);
      tick();
      tick();
      chk_all("st.gap4", 20'h0, 32'h9000_0009, 1'b1, 1'b1, 1'b0, 16'd6);
      drive(1'b1, 32'h8000_0008);     tick();
      chk_all("st.dH", 20'h0, 32'h8000_0008, 1'b0, 1'b1, 1'b0, 16'd6);
      drive(1'b0, 32'h0);             tick();
      chk_all("st.sH", 20'h00010, 32'h8000_0008, 1'b1, 1'b1, 1'b0, 16'd7);

      // Zero-count header: desync to HUNT without error.
      drive(1'b1, 32'hABCD_0005);     tick();
      chk_all("desync", 20'h0, 32'h8000_0008, 1'b1, 1'b0, 1'b0, 16'd7);

      // Reset while a strobe is pending.
      drive(1'b1, SYNC);              tick();
      drive(1'b1, 32'h0000_0201);     tick();
      drive(1'b1, 32'h1111_2222);     tick();
      chk_all("mr.data", 20'h0, 32'h1111_2222, 1'b0, 1'b1, 1'b0, 16'd7);
      resetn = 1'b0;
      drive(1'b0, 32'h0);             tick();
      chk_all("mr.reset", 20'h0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
      resetn = 1'b1;                  tick();
      chk_all("mr.after", 20'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd0);
      tick();
      chk_all("mr.idle", 20'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
